// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the run/debug sequencer.
package run_ctrl_pkg;

  localparam int HOST_DATA_W = 16;

  typedef enum logic [2:0] {
    CMD_NOP       = 3'd0,
    CMD_WRITE     = 3'd1,
    CMD_RUN       = 3'd2,
    CMD_HALT      = 3'd3,
    CMD_STEP      = 3'd4,
    CMD_RESET_CPU = 3'd5,
    CMD_SET_BP    = 3'd6,
    CMD_CLR_BP    = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    ST_RESET_HOLD = 2'd0,
    ST_HALTED     = 2'd1,
    ST_RUN        = 2'd2,
    ST_STEP       = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE      = 2'd0,
    CAUSE_HOST      = 2'd1,
    CAUSE_BP        = 2'd2,
    CAUSE_STEP_DONE = 2'd3
  } cause_e;

endpackage

// File: rtl/run_ctrl_bp.sv
// Breakpoint unit: address/enable registers, one-shot skip flag and pc compare.
module run_ctrl_bp #(
  parameter int WORD_W  = 32,
  parameter int PROG_AW = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               set_bp,
  input  logic               clr_bp,
  input  logic [PROG_AW-1:0] bp_addr_in,
  input  logic               arm_skip,
  input  logic               run_cycle,
  input  logic [WORD_W-1:0]  cpu_pc,
  output logic               bp_hit,
  output logic               bp_skip
);

  logic [PROG_AW-1:0] bp_addr_q, bp_addr_d;
  logic               bp_en_q, bp_en_d;
  logic               bp_skip_q, bp_skip_d;

  // Breakpoint address is a halfword index; the core pc is a byte address.
  assign bp_hit  = bp_en_q && (cpu_pc == WORD_W'({bp_addr_q, 1'b0}));
  assign bp_skip = bp_skip_q;

  always_comb begin
    bp_addr_d = bp_addr_q;
    bp_en_d   = bp_en_q;
    bp_skip_d = bp_skip_q;
    if (set_bp) begin
      bp_addr_d = bp_addr_in;
      bp_en_d   = 1'b1;
    end else if (clr_bp) begin
      bp_en_d = 1'b0;
    end
    if (arm_skip) begin
      bp_skip_d = 1'b1;
    end else if (run_cycle) begin
      bp_skip_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bp_addr_q <= '0;
      bp_en_q   <= 1'b0;
      bp_skip_q <= 1'b0;
    end else begin
      bp_addr_q <= bp_addr_d;
      bp_en_q   <= bp_en_d;
      bp_skip_q <= bp_skip_d;
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Run/debug sequencer: owns core reset and clock enable, arbitrates program-memory writes.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int WORD_W  = 32,
  parameter int PROG_AW = 12,
  parameter int RST_CYC = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   host_valid,
  output logic                   host_ready,
  input  logic [2:0]             host_cmd,
  input  logic [PROG_AW-1:0]     host_addr,
  input  logic [HOST_DATA_W-1:0] host_data,
  output logic                   prog_we,
  output logic [PROG_AW-1:0]     prog_waddr,
  output logic [HOST_DATA_W-1:0] prog_wdata,
  input  logic [WORD_W-1:0]      cpu_pc,
  output logic                   cpu_rst,
  output logic                   cpu_clk_en,
  output logic [1:0]             status_state,
  output logic [1:0]             halt_cause,
  output logic                   halted_pulse,
  output logic [WORD_W-1:0]      cycle_count
);

  localparam int RC_W = $clog2(RST_CYC + 1);

  // Host handshake: a command is taken on any cycle where host_valid && host_ready;
  // host_ready depends only on host_cmd and the current state, never on host_valid.

  state_e                 state_q, state_d;
  cause_e                 cause_q, cause_d;
  logic [RC_W-1:0]        rst_cnt_q, rst_cnt_d;
  logic [HOST_DATA_W-1:0] step_cnt_q, step_cnt_d;
  logic [WORD_W-1:0]      cycle_q, cycle_d;
  logic                   cpu_rst_q, cpu_rst_d;
  logic                   prog_we_q, prog_we_d;
  logic [PROG_AW-1:0]     waddr_q, waddr_d;
  logic [HOST_DATA_W-1:0] wdata_q, wdata_d;
  logic                   pulse_q, pulse_d;

  cmd_e cmd;
  logic busy, accept, halt_acc, rstcpu_acc, run_acc, step_acc;
  logic bp_hit, bp_skip;

  assign cmd        = cmd_e'(host_cmd);
  assign busy       = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign accept     = host_valid && host_ready;
  assign halt_acc   = accept && (cmd == CMD_HALT) && busy;
  assign rstcpu_acc = accept && (cmd == CMD_RESET_CPU);
  assign run_acc    = accept && (cmd == CMD_RUN) && (state_q == ST_HALTED);
  assign step_acc   = accept && (cmd == CMD_STEP) && (state_q == ST_HALTED)
                      && (host_data != '0);

  always_comb begin
    host_ready = 1'b1;
    case (cmd)
      CMD_WRITE:          host_ready = !busy;
      CMD_RUN, CMD_STEP:  host_ready = (state_q != ST_RESET_HOLD);
      default:            host_ready = 1'b1;
    endcase
  end

  // HALT and RESET_CPU suppress the core cycle in their own acceptance cycle.
  always_comb begin
    cpu_clk_en = 1'b0;
    case (state_q)
      ST_RUN:  cpu_clk_en = (!bp_hit || bp_skip) && !halt_acc && !rstcpu_acc;
      ST_STEP: cpu_clk_en = !halt_acc && !rstcpu_acc;
      default: cpu_clk_en = 1'b0;
    endcase
  end

  run_ctrl_bp #(
    .WORD_W  (WORD_W),
    .PROG_AW (PROG_AW)
  ) u_bp (
    .clk        (clk),
    .rst        (rst),
    .set_bp     (accept && (cmd == CMD_SET_BP)),
    .clr_bp     (accept && (cmd == CMD_CLR_BP)),
    .bp_addr_in (host_addr),
    .arm_skip   (run_acc),
    .run_cycle  (state_q == ST_RUN),
    .cpu_pc     (cpu_pc),
    .bp_hit     (bp_hit),
    .bp_skip    (bp_skip)
  );

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    rst_cnt_d  = rst_cnt_q;
    step_cnt_d = step_cnt_q;
    cycle_d    = cpu_clk_en ? cycle_q + WORD_W'(1) : cycle_q;
    prog_we_d  = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    pulse_d    = 1'b0;

    if (accept && (cmd == CMD_WRITE)) begin
      prog_we_d = 1'b1;
      waddr_d   = host_addr;
      wdata_d   = host_data;
    end

    if (rstcpu_acc) begin
      state_d   = ST_RESET_HOLD;
      rst_cnt_d = RC_W'(RST_CYC);
      cycle_d   = '0;
      cause_d   = CAUSE_NONE;
    end else begin
      case (state_q)
        ST_RESET_HOLD: begin
          rst_cnt_d = rst_cnt_q - RC_W'(1);
          if (rst_cnt_q <= RC_W'(1)) state_d = ST_HALTED;
        end
        ST_HALTED: begin
          if (run_acc) begin
            state_d = ST_RUN;
            cause_d = CAUSE_NONE;
          end else if (step_acc) begin
            state_d    = ST_STEP;
            step_cnt_d = host_data;
            cause_d    = CAUSE_NONE;
          end
        end
        ST_RUN: begin
          if (halt_acc) begin
            state_d = ST_HALTED;
            cause_d = CAUSE_HOST;
            pulse_d = 1'b1;
          end else if (bp_hit && !bp_skip) begin
            state_d = ST_HALTED;
            cause_d = CAUSE_BP;
            pulse_d = 1'b1;
          end
        end
        ST_STEP: begin
          if (halt_acc) begin
            state_d = ST_HALTED;
            cause_d = CAUSE_HOST;
            pulse_d = 1'b1;
          end else begin
            step_cnt_d = step_cnt_q - HOST_DATA_W'(1);
            if (step_cnt_q == HOST_DATA_W'(1)) begin
              state_d = ST_HALTED;
              cause_d = CAUSE_STEP_DONE;
              pulse_d = 1'b1;
            end
          end
        end
        default: state_d = ST_RESET_HOLD;
      endcase
    end

    cpu_rst_d = (state_d == ST_RESET_HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RESET_HOLD;
      cause_q    <= CAUSE_NONE;
      rst_cnt_q  <= RC_W'(RST_CYC);
      step_cnt_q <= '0;
      cycle_q    <= '0;
      cpu_rst_q  <= 1'b1;
      prog_we_q  <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      rst_cnt_q  <= rst_cnt_d;
      step_cnt_q <= step_cnt_d;
      cycle_q    <= cycle_d;
      cpu_rst_q  <= cpu_rst_d;
      prog_we_q  <= prog_we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      pulse_q    <= pulse_d;
    end
  end

  assign cpu_rst      = cpu_rst_q;
  assign prog_we      = prog_we_q;
  assign prog_waddr   = waddr_q;
  assign prog_wdata   = wdata_q;
  assign status_state = state_q;
  assign halt_cause   = cause_q;
  assign halted_pulse = pulse_q;
  assign cycle_count  = cycle_q;

endmodule
